// File: rtl/spi_master_tx_if.sv
// ---------------------------------------------------------------------------
// spi_master_tx_if
// Bundles the request side (start/data) and the serial/status side
// (mosi/sclk/cs_n/busy/done) of the SPI transmit master.
//   master modport : the SPI transmitter itself (takes start/data, drives
//                    the serial lines and status)
//   slave modport  : the requester / downstream observer
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface spi_master_tx_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             mosi;
  logic             sclk;
  logic             cs_n;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    input  data,
    output mosi,
    output sclk,
    output cs_n,
    output busy,
    output done
  );

  modport slave (
    output start,
    output data,
    input  mosi,
    input  sclk,
    input  cs_n,
    input  busy,
    input  done
  );
endinterface

// File: rtl/spi_master_tx.sv
// ---------------------------------------------------------------------------
// spi_master_tx
// Mode-0 style SPI transmit-only master. A word is latched on an accepted
// start and shifted out MSB first: one SETUP half-period with sclk low,
// then WIDTH sclk high phases separated by low phases, where the final low
// phase is the HOLD phase (mosi=0, cs_n still low). done pulses for one
// cycle as cs_n returns high. All outputs are registered.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (deassertion synchronized outside)
//   bus    : spi_master_tx_if.master
//            start (in)  transfer request, only looked at in IDLE
//            data  (in)  word to send, latched on acceptance
//            mosi  (out) serial data, MSB first
//            sclk  (out) serial clock, CLK_DIV clk cycles per half-period
//            cs_n  (out) active-low frame enable
//            busy  (out) high from acceptance until done
//            done  (out) one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_master_tx #(
  parameter int WIDTH   = 4,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_master_tx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam logic [7:0] RELOAD   = 8'(CLK_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;     // half-period down-counter
  logic [4:0]       bit_q, bit_d;     // sclk rises still to come after the current one
  logic [WIDTH-1:0] sr_q, sr_d;       // shift register, MSB drives mosi
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             expire;
  assign expire = (cnt_q == 8'd0);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, counters and shift register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          cnt_d   = RELOAD;
          bit_d   = LAST_BIT;
          sr_d    = bus.data;
        end
      end
      SETUP: begin
        if (expire) begin
          state_d = SHIFT_HI;
          cnt_d   = RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SHIFT_HI: begin
        if (expire) begin
          cnt_d = RELOAD;
          if (bit_q == 5'd0) begin
            // Last rise issued: the trailing low phase is HOLD with mosi parked low.
            state_d = HOLD;
            sr_d    = '0;
          end else begin
            state_d = SHIFT_LO;
            sr_d    = sr_q << 1;
            bit_d   = bit_q - 5'd1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SHIFT_LO: begin
        if (expire) begin
          state_d = SHIFT_HI;
          cnt_d   = RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (expire) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        bit_d   = 5'd0;
        sr_d    = '0;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    sclk_d = (state_d == SHIFT_HI);
    cs_n_d = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_q == HOLD) && (state_d == IDLE);
    mosi_d = (state_d == IDLE) ? 1'b0 : sr_d[WIDTH-1];
  end

  assign bus.sclk = sclk_q;
  assign bus.mosi = mosi_q;
  assign bus.cs_n = cs_n_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_master_tx
// Directed bench for spi_master_tx: a default instance (WIDTH=4, CLK_DIV=4)
// and a fast instance (WIDTH=8, CLK_DIV=1), each feeding a small receiver
// shift register clocked by sclk. Cycle numbers count from the clock edge
// that accepted start (c=0 is the sample right after that edge).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_tx;

  logic clk;
  logic rst_n;

  spi_master_tx_if #(.WIDTH(4)) b0 ();
  spi_master_tx_if #(.WIDTH(8)) b1 ();

  spi_master_tx #(.WIDTH(4), .CLK_DIV(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.master)
  );

  spi_master_tx #(.WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream shift registers sampling mosi on sclk rising edges
  logic [3:0] rx0;
  logic [7:0] rx1;
  always @(posedge b0.sclk) rx0 <= {rx0[2:0], b0.mosi};
  always @(posedge b1.sclk) rx1 <= {rx1[6:0], b1.mosi};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Raise start with data d; returns at the first sample after acceptance
  // with start still high.
  task automatic start0(input logic [3:0] d);
    @(negedge clk);
    b0.start = 1'b1;
    b0.data  = d;
    @(negedge clk);
  endtask

  // Observe dut0 from c=0 until done (or budget). Optionally re-asserts
  // start with other data at cycle inj_c for one cycle.
  task automatic watch0(input int inj_c, input logic [3:0] inj_d,
                        output int done_c, output int busy_n,
                        output int first_r, output int last_r, output int n_r);
    logic prev;
    prev    = 1'b0;
    done_c  = -1;
    busy_n  = 0;
    first_r = -1;
    last_r  = -1;
    n_r     = 0;
    for (int c = 0; c < 200; c++) begin
      if (b0.busy) busy_n++;
      if (b0.sclk && !prev) begin
        if (n_r == 0) first_r = c;
        last_r = c;
        n_r++;
      end
      prev = b0.sclk;
      if (b0.done) begin
        done_c = c;
        break;
      end
      if (c == inj_c) begin
        b0.start = 1'b1;
        b0.data  = inj_d;
      end else if (c == inj_c + 1) begin
        b0.start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  int done_c, busy_n, first_r, last_r, n_r, seen;
  logic prev1;

  initial begin
    rst_n    = 1'b0;
    b0.start = 1'b0;
    b0.data  = '0;
    b1.start = 1'b0;
    b1.data  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(b0.cs_n), 1);
    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_sclk", 32'(b0.sclk), 0);
    chk("rst_mosi", 32'(b0.mosi), 0);
    chk("rst_done", 32'(b0.done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 4'b1011 frame; data changes right after acceptance
    start0(4'b1011);
    b0.start = 1'b0;
    b0.data  = 4'b0100;
    chk("acc_cs_n", 32'(b0.cs_n), 0);
    chk("acc_busy", 32'(b0.busy), 1);
    chk("acc_mosi", 32'(b0.mosi), 1);
    chk("acc_sclk", 32'(b0.sclk), 0);
    watch0(-10, 4'b0000, done_c, busy_n, first_r, last_r, n_r);
    chk("f1_done_cycle", done_c, 36);
    chk("f1_busy_cycles", busy_n, 36);
    chk("f1_first_rise", first_r, 4);
    chk("f1_last_rise", last_r, 28);
    chk("f1_rises", n_r, 4);
    chk("f1_rx", 32'(rx0), 32'hB);
    chk("f1_end_cs_n", 32'(b0.cs_n), 1);
    chk("f1_end_busy", 32'(b0.busy), 0);
    @(negedge clk);
    chk("f1_done_pulse", 32'(b0.done), 0);
    repeat (3) @(negedge clk);

    // 4'b1111 frame with a start/0000 request injected at cycle 10
    start0(4'b1111);
    b0.start = 1'b0;
    watch0(10, 4'b0000, done_c, busy_n, first_r, last_r, n_r);
    chk("f2_done_cycle", done_c, 36);
    chk("f2_rises", n_r, 4);
    chk("f2_rx", 32'(rx0), 32'hF);
    @(negedge clk);
    chk("f2_no_requeue", 32'(b0.busy), 0);
    repeat (3) @(negedge clk);

    // Back-to-back 4'b1001 then 4'b0110 with start held high
    start0(4'b1001);
    b0.data = 4'b0110;
    watch0(-10, 4'b0000, done_c, busy_n, first_r, last_r, n_r);
    chk("b2b1_done_cycle", done_c, 36);
    chk("b2b1_rx", 32'(rx0), 32'h9);
    chk("b2b1_gap_cs_n", 32'(b0.cs_n), 1);
    @(negedge clk);
    b0.start = 1'b0;
    chk("b2b2_cs_n", 32'(b0.cs_n), 0);
    chk("b2b2_busy", 32'(b0.busy), 1);
    chk("b2b2_done_pulse", 32'(b0.done), 0);
    chk("b2b2_mosi", 32'(b0.mosi), 0);
    watch0(-10, 4'b0000, done_c, busy_n, first_r, last_r, n_r);
    chk("b2b2_done_cycle", done_c, 36);
    chk("b2b2_busy_cycles", busy_n, 36);
    chk("b2b2_rx", 32'(rx0), 32'h6);
    repeat (3) @(negedge clk);

    // Asynchronous reset at cycle 15 of a 4'b1111 frame (sclk high there)
    start0(4'b1111);
    b0.start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_rst_sclk", 32'(b0.sclk), 1);
    chk("pre_rst_cs_n", 32'(b0.cs_n), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs_n", 32'(b0.cs_n), 1);
    chk("arst_busy", 32'(b0.busy), 0);
    chk("arst_sclk", 32'(b0.sclk), 0);
    chk("arst_mosi", 32'(b0.mosi), 0);
    chk("arst_done", 32'(b0.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b0.done) seen++;
    end
    chk("arst_no_done", seen, 0);
    start0(4'b0101);
    b0.start = 1'b0;
    watch0(-10, 4'b0000, done_c, busy_n, first_r, last_r, n_r);
    chk("f4_done_cycle", done_c, 36);
    chk("f4_rises", n_r, 4);
    chk("f4_rx", 32'(rx0), 32'h5);
    repeat (3) @(negedge clk);

    // WIDTH=8, CLK_DIV=1 instance with 8'hA5
    @(negedge clk);
    b1.start = 1'b1;
    b1.data  = 8'hA5;
    @(negedge clk);
    b1.start = 1'b0;
    b1.data  = 8'h00;
    prev1   = 1'b0;
    done_c  = -1;
    busy_n  = 0;
    first_r = -1;
    last_r  = -1;
    n_r     = 0;
    for (int c = 0; c < 100; c++) begin
      if (b1.busy) busy_n++;
      if (b1.sclk && !prev1) begin
        if (n_r == 0) first_r = c;
        last_r = c;
        n_r++;
      end
      prev1 = b1.sclk;
      if (b1.done) begin
        done_c = c;
        break;
      end
      @(negedge clk);
    end
    chk("f8_busy_cycles", busy_n, 17);
    chk("f8_first_rise", first_r, 1);
    chk("f8_last_rise", last_r, 15);
    chk("f8_rises", n_r, 8);
    chk("f8_done_cycle", done_c, 17);
    chk("f8_rx", 32'(rx1), 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the word length in bits; legal range 1..16.
REQ-002 SHALL have parameter CLK_DIV, default 4, giving clk cycles per sclk half-period; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: transfer request, sampled only in IDLE.
REQ-006 SHALL have port data, input, WIDTH bits: the word to transmit, latched when start is accepted.
REQ-007 SHALL have port mosi, output, 1 bit: serial data to the downstream shift register's MOSI input.
REQ-008 SHALL have port sclk, output, 1 bit: serial clock to the downstream shift register's clk input.
REQ-009 SHALL have port cs_n, output, 1 bit: active-low frame enable, low for the whole transfer.
REQ-010 SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at transfer end.

Function
REQ-012 SHALL implement the FSM states IDLE, SETUP, SHIFT_HI, SHIFT_LO and HOLD; all outputs SHALL be registered.
REQ-013 IDLE: the block SHALL drive sclk=0, mosi=0, cs_n=1 and busy=0.
REQ-014 Start acceptance: start=1 in IDLE at edge k SHALL latch data into a shift register, and after edge k drive cs_n=0, busy=1, mosi=data[WIDTH-1] and sclk=0, then enter SETUP.
REQ-015 SETUP SHALL last CLK_DIV cycles with sclk=0, then enter SHIFT_HI.
REQ-016 SHIFT_HI SHALL drive sclk=1 for CLK_DIV cycles, with mosi stable; the downstream register samples on this rising edge.
REQ-017 SHIFT_LO SHALL drive sclk=0 for CLK_DIV cycles; on entry it SHALL shift so that mosi presents the next lower bit; it SHALL then return to SHIFT_HI until WIDTH rising edges have been issued.
REQ-018 After the final SHIFT_LO, mosi SHALL be 0 and the state SHALL be HOLD; HOLD SHALL keep cs_n=0 for CLK_DIV cycles.
REQ-019 On leaving HOLD, the block SHALL drive cs_n=1, busy=0 and done=1 for exactly one cycle, and return to IDLE.
REQ-020 Bit order SHALL be MSB first, so that the downstream register's msg[WIDTH-1:0] equals the latched data after WIDTH sclk rises.
REQ-021 sclk rising edges SHALL occur after clk edges k+CLK_DIV+2*CLK_DIV*i, for i=0..WIDTH-1.
REQ-022 busy SHALL be high for exactly (2*WIDTH+1)*CLK_DIV cycles per transfer; for the defaults this is 36 cycles.
REQ-023 The half-period counter SHALL be 8 bits, reload to CLK_DIV-1 and count down; the bit counter SHALL be 5 bits. Neither counter SHALL wrap during a legal transfer.
REQ-024 start while busy=1 SHALL be ignored: no queuing, and no change to the in-flight data.
REQ-025 A start on the same cycle as done=1 SHALL be accepted (back-to-back), with cs_n low again on the following cycle.
REQ-026 Changes on data after acceptance SHALL NOT affect the transmitted word.
REQ-027 CLK_DIV=1 SHALL yield sclk at clk/2 with identical sequencing.

Reset
REQ-028 rst_n=0 SHALL immediately, asynchronously, force state=IDLE, sclk=0, mosi=0, cs_n=1, busy=0, done=0, and clear both counters and the shift register.
REQ-029 Reset mid-transfer SHALL abort the frame with no done pulse; the first start after rst_n rises SHALL begin a fresh full transfer.
REQ-030 The rst_n deassertion edge SHALL be synchronized into clk by the instantiating top level; the block SHALL treat rst_n as asynchronous on assertion only.

Verification
REQ-031 Defaults with data=4'b1011 and a 1-cycle start: mosi SHALL read 1,0,1,1 at the 4 sclk rises, a downstream 4-flop chain SHALL hold 4'b1011, and done SHALL pulse 36 cycles after acceptance.
REQ-032 start re-asserted with data=4'b0000 at cycle 10 of a 4'b1111 transfer: this SHALL be ignored, and 1,1,1,1 SHALL be shifted.
REQ-033 Two back-to-back words, 4'b1001 then 4'b0110, with start held high through done: cs_n SHALL go high for exactly 1 cycle between frames and both words SHALL be received intact.
REQ-034 rst_n pulsed low at cycle 15 of a transfer: all outputs SHALL reach their idle values without waiting for a clk edge, no done SHALL pulse, and a following start with 4'b0101 SHALL transmit correctly.
REQ-035 CLK_DIV=1, WIDTH=8, data=8'hA5: sclk period SHALL be 2 clk cycles, busy SHALL be high for 17 cycles, and the received word SHALL be 8'hA5.
